// File: rtl/pacman_tick_ctrl.sv
// Game-tick sequencer for an Avalon interval timer: programs the period,
// starts it, then turns each serviced timeout into a one-cycle tick pulse.
module pacman_tick_ctrl #(
  parameter logic [3:0] CTRL_RUN  = 4'h7,
  parameter logic [3:0] CTRL_HALT = 4'h8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        reload_req,
  output logic [3:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic        tm_irq,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, WR_STOP
  } state_t;

  state_t      state, next;
  logic [31:0] period_q;
  logic        pend_q, pend_d;
  logic [15:0] cnt_q;

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (enable) next = WR_P0;
      WR_P0:   next = enable ? WR_P1   : WR_STOP;
      WR_P1:   next = enable ? WR_P2   : WR_STOP;
      WR_P2:   next = enable ? WR_P3   : WR_STOP;
      WR_P3:   next = enable ? WR_CTRL : WR_STOP;
      WR_CTRL: next = enable ? RUN     : WR_STOP;
      RUN: begin
        if (!enable)                  next = WR_STOP;
        else if (tm_irq)              next = CLR;
        else if (reload_req || pend_q) next = WR_P0;
      end
      CLR:     next = enable ? RUN : WR_STOP;
      WR_STOP: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // A reload that is not taken this cycle waits until the next sequence starts.
  always_comb begin
    pend_d = pend_q;
    if (next == WR_P0 || next == IDLE) pend_d = 1'b0;
    else if (reload_req)               pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      period_q <= '0;
      pend_q   <= 1'b0;
      tick     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state  <= next;
      pend_q <= pend_d;
      tick   <= (next == CLR);
      if (next == WR_P0 && state != WR_P0) period_q <= period;
      if (next == CLR)          cnt_q <= cnt_q + 16'd1;
      else if (next == WR_CTRL) cnt_q <= '0;
    end
  end

  assign tick_count = cnt_q;
  assign busy       = (state != IDLE) && (state != RUN);

  // Bus decode depends on the registered state only.
  always_comb begin
    tm_chipselect = 1'b1;
    tm_write_n    = 1'b0;
    tm_address    = 4'd0;
    tm_writedata  = 16'h0;
    case (state)
      WR_P0:   begin tm_address = 4'd2; tm_writedata = period_q[15:0];  end
      WR_P1:   begin tm_address = 4'd3; tm_writedata = period_q[31:16]; end
      WR_P2:   tm_address = 4'd4;
      WR_P3:   tm_address = 4'd5;
      WR_CTRL: begin tm_address = 4'd1; tm_writedata = {12'h0, CTRL_RUN};  end
      CLR:     tm_address = 4'd0;
      WR_STOP: begin tm_address = 4'd1; tm_writedata = {12'h0, CTRL_HALT}; end
      default: begin tm_chipselect = 1'b0; tm_write_n = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_pacman_tick_ctrl.sv
// Directed bench for pacman_tick_ctrl: bus sequence, tick counting, wrap,
// irq/reload collision, enable drop mid-sequence and mid-sequence reset.
module tb_pacman_tick_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] period;
  logic        reload_req;
  logic [3:0]  tm_address;
  logic        tm_chipselect;
  logic        tm_write_n;
  logic [15:0] tm_writedata;
  logic        tm_irq;
  logic        tick;
  logic [15:0] tick_count;
  logic        busy;

  int total = 0;
  int fails = 0;

  pacman_tick_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .reload_req(reload_req), .tm_address(tm_address), .tm_chipselect(tm_chipselect),
    .tm_write_n(tm_write_n), .tm_writedata(tm_writedata), .tm_irq(tm_irq),
    .tick(tick), .tick_count(tick_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected: chipselect, write_n, address, writedata, busy, tick, tick_count
  task automatic chk(input string tag, input logic cs, input logic wn, input logic [3:0] a,
                     input logic [15:0] d, input logic b, input logic t, input logic [15:0] c);
    logic [39:0] obs, exp;
    obs = {tm_chipselect, tm_write_n, tm_address, tm_writedata, busy, tick, tick_count};
    exp = {cs, wn, a, d, b, t, c};
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; period = 32'h0001C34F; reload_req = 1'b0; tm_irq = 1'b0;
    #3;
    chk("reset", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("idle_no_enable", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);

    // Programming sequence; period changes mid-sequence must be ignored
    enable = 1'b1;
    step(); chk("wr_p0", 1, 0, 4'd2, 16'hC34F, 1, 0, 16'h0);
    period = 32'hDEADBEEF;
    step(); chk("wr_p1", 1, 0, 4'd3, 16'h0001, 1, 0, 16'h0);
    step(); chk("wr_p2", 1, 0, 4'd4, 16'h0000, 1, 0, 16'h0);
    step(); chk("wr_p3", 1, 0, 4'd5, 16'h0000, 1, 0, 16'h0);
    step(); chk("wr_ctrl", 1, 0, 4'd1, 16'h0007, 1, 0, 16'h0);
    step(); chk("run", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);
    step(); chk("run_hold", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);

    // One serviced timeout
    tm_irq = 1'b1;
    step(); chk("clr_tick", 1, 0, 4'd0, 16'h0, 1, 1, 16'h1);
    tm_irq = 1'b0;
    step(); chk("clr_back_run", 0, 1, 4'd0, 16'h0, 0, 0, 16'h1);

    // Counter wrap: preload the count to 0xFFFF while idling in RUN
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    tm_irq = 1'b1;
    step(); chk("wrap", 1, 0, 4'd0, 16'h0, 1, 1, 16'h0);
    tm_irq = 1'b0;
    step(); chk("wrap_run", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);

    // irq and reload together: CLR first, then reprogram from pending flag
    period = 32'h00000010;
    tm_irq = 1'b1; reload_req = 1'b1;
    step(); chk("coll_clr", 1, 0, 4'd0, 16'h0, 1, 1, 16'h1);
    tm_irq = 1'b0; reload_req = 1'b0;
    step(); chk("coll_run", 0, 1, 4'd0, 16'h0, 0, 0, 16'h1);
    step(); chk("coll_p0", 1, 0, 4'd2, 16'h0010, 1, 0, 16'h1);
    step(); chk("coll_p1", 1, 0, 4'd3, 16'h0000, 1, 0, 16'h1);
    step(); step();
    step(); chk("coll_ctrl", 1, 0, 4'd1, 16'h0007, 1, 0, 16'h0);
    step(); chk("coll_run2", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);

    tm_irq = 1'b1;
    step(); chk("tick_again", 1, 0, 4'd0, 16'h0, 1, 1, 16'h1);
    tm_irq = 1'b0;
    step();

    // Reload, then drop enable during WR_P1
    reload_req = 1'b1;
    step(); chk("reload_p0", 1, 0, 4'd2, 16'h0010, 1, 0, 16'h1);
    reload_req = 1'b0;
    step(); chk("drop_p1", 1, 0, 4'd3, 16'h0000, 1, 0, 16'h1);
    enable = 1'b0;
    step(); chk("stop_write", 1, 0, 4'd1, 16'h0008, 1, 0, 16'h1);
    step(); chk("stop_idle", 0, 1, 4'd0, 16'h0, 0, 0, 16'h1);
    step(); chk("stop_idle2", 0, 1, 4'd0, 16'h0, 0, 0, 16'h1);

    // Reset in the middle of WR_P2
    enable = 1'b1;
    step(); step();
    step(); chk("pre_rst_p2", 1, 0, 4'd4, 16'h0000, 1, 0, 16'h1);
    #2;
    reset_n = 1'b0; enable = 1'b0;
    #1;
    chk("rst_async", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);
    step();
    reset_n = 1'b1;
    step(); chk("post_rst1", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);
    step(); step();
    chk("post_rst3", 0, 1, 4'd0, 16'h0, 0, 0, 16'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/pacman_tick_ctrl.md
PACMAN_TICK_CTRL -- requirements
Module: pacman_tick_ctrl

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 4'h7, control word written to start the timer (bit2 START, bit1 CONT, bit0 ITO).
REQ-002 SHALL have parameter CTRL_HALT, default 4'h8, control word written to stop the timer (bit3 STOP, ITO/CONT cleared).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, level; 1 = keep the game tick running.
REQ-006 SHALL have port period, input, 32, timer period in clk cycles minus one.
REQ-007 SHALL have port reload_req, input, 1, single-cycle pulse requesting reprogramming with the current period.
REQ-008 SHALL have port tm_address, output, 4, address to the interval timer slave.
REQ-009 SHALL have port tm_chipselect, output, 1, timer slave select.
REQ-010 SHALL have port tm_write_n, output, 1, active-low timer write strobe.
REQ-011 SHALL have port tm_writedata, output, 16, timer write data.
REQ-012 SHALL have port tm_irq, input, 1, timer interrupt, level, held until the status register is written.
REQ-013 SHALL have port tick, output, 1, one-cycle game-tick pulse per serviced timeout.
REQ-014 SHALL have port tick_count, output, 16, count of ticks since the last programming sequence.
REQ-015 SHALL have port busy, output, 1, 1 in every state except IDLE and RUN.

Function
REQ-016 SHALL implement states IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, WR_STOP; every write state lasts exactly one cycle, because the slave has no wait states.
REQ-017 SHALL, in each write state, drive tm_chipselect=1 and tm_write_n=0; all other states SHALL drive tm_chipselect=0, tm_write_n=1, tm_address=0 and tm_writedata=0.
REQ-018 SHALL issue the write states with these address/data pairs: WR_P0 2/period_q[15:0]; WR_P1 3/period_q[31:16]; WR_P2 4/0; WR_P3 5/0; WR_CTRL 1/{12'h0,CTRL_RUN}; CLR 0/0; WR_STOP 1/{12'h0,CTRL_HALT}.
REQ-019 SHALL capture period into period_q on every transition into WR_P0; changes to period during a sequence SHALL be ignored.
REQ-020 SHALL transition IDLE->WR_P0 when enable=1; otherwise it SHALL stay in IDLE.
REQ-021 SHALL step WR_P0->WR_P1->WR_P2->WR_P3->WR_CTRL->RUN unconditionally, with no gap cycles, provided enable stays 1.
REQ-022 SHALL clear tick_count to 0 in WR_CTRL.
REQ-023 SHALL, from RUN, use this priority: enable=0 -> WR_STOP; else tm_irq=1 -> CLR; else reload_req=1 -> WR_P0; else stay in RUN.
REQ-024 SHALL assert tick for the single CLR cycle and increment tick_count modulo 2^16 in that cycle (0xFFFF wraps to 0x0000).
REQ-025 SHALL go CLR->RUN; a reload_req that arrives in CLR SHALL be held pending and taken from RUN on the next cycle unless tm_irq is already reasserted.
REQ-026 SHALL latch reload_req in a pending flag whenever it is not consumed in the same cycle, and clear the flag on entry to WR_P0 or IDLE; the pending flag SHALL count as reload_req in REQ-023.
REQ-027 SHALL, when enable=0 in any state WR_P0..WR_CTRL or CLR, complete that state's write and then go to WR_STOP instead of the normal successor.
REQ-028 SHALL go WR_STOP->IDLE unconditionally.
REQ-029 SHALL ignore tm_irq in every state other than RUN.
REQ-030 SHALL assert busy combinationally from the current state.
REQ-031 SHALL register tick and tick_count; all bus outputs SHALL be decoded from the registered state only.

Reset
REQ-032 SHALL, on reset_n=0 and at any time including mid-sequence, immediately force state=IDLE, period_q=0, pending flag=0, tick=0, tick_count=0, busy=0, tm_chipselect=0, tm_write_n=1, tm_address=0, tm_writedata=0.
REQ-033 SHALL begin a fresh sequence after reset release only when enable=1, with no partial write replayed.

Verification
REQ-034 SHALL be verified for this case: period=0x0001C34F, enable rises at cycle 0 -> cycles 1..5 write addr 2/0xC34F, 3/0x0001, 4/0, 5/0, 1/0x0007, with RUN from cycle 6 and busy=1 in cycles 1..5.
REQ-035 SHALL be verified for this case: tm_irq asserted in RUN -> next cycle write addr 0 data 0, with tick=1 and tick_count 0->1, then return to RUN.
REQ-036 SHALL be verified for this case: tick_count=0xFFFF plus one irq -> tick_count=0x0000.
REQ-037 SHALL be verified for this case: tm_irq and reload_req in the same RUN cycle -> CLR first, then the WR_P0..WR_CTRL sequence, then tick_count=0.
REQ-038 SHALL be verified for this case: enable dropped during WR_P1 -> WR_P1 write completes, then one write addr 1 data 0x0008, then IDLE.
REQ-039 SHALL be verified for this case: reset_n low during WR_P2 -> all outputs at reset values in the same cycle, and no bus activity after release while enable=0.
